// File: rtl/steer_pkg.sv
// steer_pkg: shared types and helpers for the steering-bus receiver.
//   state_t          - receiver FSM states
//   DEFAULT_LANES    - default ring width
//   MAX_LANES        - widest code the helper functions accept
//   onehot_to_index  - index of the lowest set bit of a code
//   onehot_legal     - true when exactly one bit of a code is set
package steer_pkg;

  typedef enum logic [1:0] {
    WAIT_DATA = 2'd0,
    ACCEPT    = 2'd1,
    SEND      = 2'd2,
    ACK       = 2'd3
  } state_t;

  localparam int DEFAULT_LANES = 4;
  localparam int MAX_LANES     = 32;

  // Lowest set bit wins, so a multi-hot code still maps to a single lane.
  function automatic int onehot_to_index(input logic [MAX_LANES-1:0] code);
    int idx;
    idx = 0;
    for (int i = MAX_LANES - 1; i >= 0; i--) begin
      if (code[i]) idx = i;
    end
    return idx;
  endfunction

  function automatic logic onehot_legal(input logic [MAX_LANES-1:0] code);
    return ($countones(code) == 1);
  endfunction

endpackage

// File: rtl/steer_sync.sv
// steer_sync: brings the asynchronous steering token into clk and flags
// when the synchronised code has held for two consecutive cycles.
//   clk, init       - clock, async active-high reset
//   steer           - asynchronous one-hot token (all-zero = NULL)
//   s_sync          - token after SYNC_STAGES flops
//   s_stable_valid  - s_sync equals its value one cycle earlier
module steer_sync
  import steer_pkg::*;
#(
  parameter int LANES       = DEFAULT_LANES,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             init,
  input  logic [LANES-1:0] steer,
  output logic [LANES-1:0] s_sync,
  output logic             s_stable_valid
);

  logic [LANES-1:0] stages [SYNC_STAGES];
  logic [LANES-1:0] s_prev;

  always_ff @(posedge clk or posedge init) begin
    if (init) begin
      for (int i = 0; i < SYNC_STAGES; i++) stages[i] <= '0;
      s_prev <= '0;
    end else begin
      stages[0] <= steer;
      for (int i = 1; i < SYNC_STAGES; i++) stages[i] <= stages[i-1];
      s_prev <= stages[SYNC_STAGES-1];
    end
  end

  assign s_sync = stages[SYNC_STAGES-1];

  // Rails of a changing token can resolve in different cycles; only a code
  // seen twice in a row is trusted.
  assign s_stable_valid = (s_sync == s_prev);

endmodule

// File: rtl/steer_rx.sv
// steer_rx: clocked receiver for the NCL four-phase steering bus. Each
// token routes one input word to the selected lane, then steer_comp asks
// the ring for NULL; it drops again once NULL has been seen.
//   clk, init   - clock, async active-high reset
//   steer       - asynchronous one-hot token from the ring
//   steer_comp  - completion to the ring (0 = want DATA, 1 = want NULL)
//   in_data/in_valid/in_ready      - word input
//   lane_data/lane_valid/lane_ready - per-lane outputs, lane i at [i*WIDTH +: WIDTH]
//   steer_err   - sticky multi-hot flag
// Build option: STEER_ONEHOT_CHECK_EN - multi-hot tokens set steer_err and
// are completed without consuming a word; otherwise the lowest set bit
// selects the lane and steer_err is tied low.
//
// state     | meaning
// WAIT_DATA | idle, steer_comp low, waiting for a stable non-zero token
// ACCEPT    | in_ready high, waiting for in_valid
// SEND      | word held on lane sel until lane_ready[sel]
// ACK       | steer_comp high, waiting for a stable NULL
module steer_rx
  import steer_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int LANES       = DEFAULT_LANES,
  parameter int SYNC_STAGES = 2
) (
  input  logic                   clk,
  input  logic                   init,
  input  logic [LANES-1:0]       steer,
  output logic                   steer_comp,
  input  logic [WIDTH-1:0]       in_data,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic [LANES*WIDTH-1:0] lane_data,
  output logic [LANES-1:0]       lane_valid,
  input  logic [LANES-1:0]       lane_ready,
  output logic                   steer_err
);

  localparam int SELW = (LANES > 1) ? $clog2(LANES) : 1;

  state_t           state, state_nxt;
  logic [SELW-1:0]  sel;
  logic [SELW-1:0]  code_idx;
  logic [LANES-1:0] s_sync;
  logic             s_stable_valid;
  logic             tok_present, tok_null;
  logic             latch_sel, take_word, lane_done;
  logic [WIDTH-1:0] lane_q [LANES];
  logic [LANES-1:0] lane_valid_q;
  logic             steer_comp_q;

  steer_sync #(
    .LANES       (LANES),
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .clk            (clk),
    .init           (init),
    .steer          (steer),
    .s_sync         (s_sync),
    .s_stable_valid (s_stable_valid)
  );

  assign tok_present = s_stable_valid && (s_sync != '0);
  assign tok_null    = s_stable_valid && (s_sync == '0);
  assign code_idx    = SELW'(onehot_to_index(MAX_LANES'(s_sync)));

`ifdef STEER_ONEHOT_CHECK_EN
  logic flag_err;
  logic err_q;
`endif

  always_ff @(posedge clk or posedge init) begin
    if (init) state <= WAIT_DATA;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    latch_sel = 1'b0;
    take_word = 1'b0;
    lane_done = 1'b0;
`ifdef STEER_ONEHOT_CHECK_EN
    flag_err  = 1'b0;
`endif
    case (state)
      WAIT_DATA: begin
        if (tok_present) begin
`ifdef STEER_ONEHOT_CHECK_EN
          if (!onehot_legal(MAX_LANES'(s_sync))) begin
            state_nxt = ACK;
            flag_err  = 1'b1;
          end else
`endif
          begin
            state_nxt = ACCEPT;
            latch_sel = 1'b1;
          end
        end
      end
      ACCEPT: begin
        if (in_valid) begin
          take_word = 1'b1;
          state_nxt = SEND;
        end
      end
      SEND: begin
        if (lane_ready[sel]) begin
          lane_done = 1'b1;
          state_nxt = ACK;
        end
      end
      ACK: begin
        // A non-zero token here is the previous one still held; keep waiting.
        if (tok_null) state_nxt = WAIT_DATA;
      end
      default: state_nxt = WAIT_DATA;
    endcase
  end

  always_ff @(posedge clk or posedge init) begin
    if (init) begin
      sel          <= '0;
      lane_valid_q <= '0;
      steer_comp_q <= 1'b0;
      for (int i = 0; i < LANES; i++) lane_q[i] <= '0;
    end else begin
      if (latch_sel) sel <= code_idx;
      if (take_word) begin
        lane_q[sel]  <= in_data;
        lane_valid_q <= LANES'(1) << sel;
      end
      if (lane_done) lane_valid_q <= '0;
      steer_comp_q <= (state_nxt == ACK);
    end
  end

`ifdef STEER_ONEHOT_CHECK_EN
  always_ff @(posedge clk or posedge init) begin
    if (init)          err_q <= 1'b0;
    else if (flag_err) err_q <= 1'b1;
  end
  assign steer_err = err_q;
`else
  assign steer_err = 1'b0;
`endif

  for (genvar i = 0; i < LANES; i++) begin : g_pack
    assign lane_data[i*WIDTH +: WIDTH] = lane_q[i];
  end

  assign lane_valid = lane_valid_q;
  assign steer_comp = steer_comp_q;
  // Depends on state only so the upstream handshake never sees lane_ready.
  assign in_ready   = (state == ACCEPT);

endmodule
